// File: rtl/yarvi_lsu.sv
// yarvi_lsu -- load-store unit between EX and WB of the yarvi pipeline.
//
// Stores are retired into an in-order store buffer (SB) and drained, one
// entry per cycle, into a single-ported byte-lane data RAM and onto the
// code_* write port whenever no load occupies the RAM port. Loads read the
// RAM in their accept cycle and produce a result exactly one cycle later.
//
// Build option:
//   LSU_FORWARD_EN  defined   -> loads merge matching SB bytes over RAM bytes
//                   undefined -> a load whose word address matches any SB
//                                entry is squashed and flagged for replay
//
// Ports:
//   clock, reset_n              clock, asynchronous active-low reset
//   valid/pc/wb_rd/wb_val       EX op; wb_val is the effective address for
//                               memory ops, the ALU result otherwise
//   readenable/writeenable      load / store
//   funct3, writedata           access size/extension, raw store data
//   fence                       hold off new ops until the SB is empty
//   ready, sb_empty             accept handshake, SB occupancy
//   me_*                        registered result, one cycle after accept
//   code_*                      drained store, registered, mask 0 when idle
module yarvi_lsu #(
  parameter int          WI_BITS   = 10,
  parameter int          SB_DEPTH  = 4,
  parameter logic [31:0] BASE_ADDR = 32'h80000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        valid,
  input  logic [31:0] pc,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_val,
  input  logic        readenable,
  input  logic        writeenable,
  input  logic [2:0]  funct3,
  input  logic [31:0] writedata,
  input  logic        fence,
  output logic        ready,
  output logic        sb_empty,
  output logic        me_valid,
  output logic [31:0] me_pc,
  output logic [4:0]  me_wb_rd,
  output logic [31:0] me_wb_val,
  output logic        me_exc_misaligned,
  output logic [31:0] me_exc_mtval,
  output logic        me_load_hit_store,
  output logic [31:0] code_address,
  output logic [31:0] code_writedata,
  output logic [3:0]  code_writemask
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  localparam int RAM_WORDS = 1 << WI_BITS;

  // store buffer storage (not reset; validity is carried by head/count)
  logic [29:0]   sb_addr [SB_DEPTH];
  logic [31:0]   sb_data [SB_DEPTH];
  logic [3:0]    sb_mask [SB_DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          fence_pending;
  logic          sb_full;

  logic [31:0]   ram [RAM_WORDS];
  logic [31:0]   ram_q;

  logic          acc, mis, ld_acc, st_acc, ld_read, ld_replay, drain;
  logic          head_in_ram;
  logic [29:0]   ld_waddr;
  logic [3:0]    st_mask;
  logic [31:0]   st_data;
  logic [PW-1:0] idx;

  logic          ld_q;
  logic [2:0]    ld_f3_q;
  logic [1:0]    ld_off_q;
  logic [31:0]   byp_val_q;
  logic [31:0]   ld_word, ld_sh;

`ifdef LSU_FORWARD_EN
  logic [3:0]    fwd_mask, fwd_mask_q;
  logic [31:0]   fwd_data, fwd_data_q;
`else
  logic          sb_hit;
`endif

  assign sb_full  = (count == CW'(SB_DEPTH));
  assign sb_empty = (count == '0);
  assign ready    = !fence_pending && !(writeenable && sb_full);
  assign acc      = valid && ready;
  assign ld_waddr = wb_val[31:2];

  // half needs a[0]==0, word needs a[1:0]==0; funct3[1:0]==3 is treated as word
  assign mis = (readenable || writeenable) &&
               (((funct3[1:0] == 2'd1) && wb_val[0]) ||
                (funct3[1] && (wb_val[1:0] != 2'b00)));

  assign ld_acc  = acc && readenable && !mis;
  assign st_acc  = acc && writeenable && !readenable && !mis;
  assign ld_read = ld_acc && !ld_replay;
  // a replayed load never touches the RAM, so the SB keeps draining
  assign drain   = (count != '0) && !ld_read;
  assign head_in_ram = (sb_addr[head][29:WI_BITS] == BASE_ADDR[31:WI_BITS+2]);

  always_comb begin
    st_mask = 4'hF;
    st_data = writedata;
    case (funct3[1:0])
      2'd0: begin
        st_mask = 4'b0001 << wb_val[1:0];
        st_data = {4{writedata[7:0]}};
      end
      2'd1: begin
        st_mask = wb_val[1] ? 4'hC : 4'h3;
        st_data = {2{writedata[15:0]}};
      end
      default: ;
    endcase
  end

  // Walk the SB oldest to youngest so younger matches overwrite older ones.
  always_comb begin
    idx = '0;
`ifdef LSU_FORWARD_EN
    fwd_mask = '0;
    fwd_data = '0;
`else
    sb_hit = 1'b0;
`endif
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (sb_addr[idx] == ld_waddr)) begin
`ifdef LSU_FORWARD_EN
        for (int b = 0; b < 4; b++) begin
          if (sb_mask[idx][b]) begin
            fwd_mask[b]        = 1'b1;
            fwd_data[8*b +: 8] = sb_data[idx][8*b +: 8];
          end
        end
`else
        sb_hit = 1'b1;
`endif
      end
    end
  end

`ifdef LSU_FORWARD_EN
  assign ld_replay = 1'b0;
`else
  assign ld_replay = sb_hit;
`endif

  // single RAM port: load read or drain write, never both in one cycle
  always_ff @(posedge clock) begin
    if (drain && head_in_ram) begin
      for (int b = 0; b < 4; b++) begin
        if (sb_mask[head][b])
          ram[sb_addr[head][WI_BITS-1:0]][8*b +: 8] <= sb_data[head][8*b +: 8];
      end
    end
    if (ld_read)
      ram_q <= ram[wb_val[WI_BITS+1:2]];
  end

  always_ff @(posedge clock) begin
    if (st_acc) begin
      sb_addr[tail] <= wb_val[31:2];
      sb_data[tail] <= st_data;
      sb_mask[tail] <= st_mask;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      fence_pending <= 1'b0;
    end else begin
      if (st_acc)
        tail <= tail + 1'b1;
      if (drain)
        head <= head + 1'b1;
      count <= count + CW'(st_acc) - CW'(drain);
      if (fence)
        fence_pending <= 1'b1;
      else if (sb_empty)
        fence_pending <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      me_valid          <= 1'b0;
      me_pc             <= '0;
      me_wb_rd          <= '0;
      me_exc_misaligned <= 1'b0;
      me_exc_mtval      <= '0;
      me_load_hit_store <= 1'b0;
      byp_val_q         <= '0;
      ld_q              <= 1'b0;
      ld_f3_q           <= '0;
      ld_off_q          <= '0;
      code_address      <= '0;
      code_writedata    <= '0;
      code_writemask    <= '0;
`ifdef LSU_FORWARD_EN
      fwd_mask_q        <= '0;
      fwd_data_q        <= '0;
`endif
    end else begin
      me_valid          <= acc && !mis && !(ld_acc && ld_replay);
      me_wb_rd          <= (acc && !mis && !(ld_acc && ld_replay)) ? wb_rd : 5'd0;
      me_exc_misaligned <= acc && mis;
      me_load_hit_store <= ld_acc && ld_replay;
      ld_q              <= ld_read;
      if (acc) begin
        me_pc     <= pc;
        byp_val_q <= wb_val;
      end
      if (acc && mis)
        me_exc_mtval <= wb_val;
      if (ld_read) begin
        ld_f3_q  <= funct3;
        ld_off_q <= wb_val[1:0];
`ifdef LSU_FORWARD_EN
        fwd_mask_q <= fwd_mask;
        fwd_data_q <= fwd_data;
`endif
      end
      code_writemask <= drain ? sb_mask[head] : 4'h0;
      if (drain) begin
        code_address   <= {sb_addr[head], 2'b00};
        code_writedata <= sb_data[head];
      end
    end
  end

  always_comb begin
`ifdef LSU_FORWARD_EN
    for (int b = 0; b < 4; b++)
      ld_word[8*b +: 8] = fwd_mask_q[b] ? fwd_data_q[8*b +: 8] : ram_q[8*b +: 8];
`else
    ld_word = ram_q;
`endif
  end

  // aligned accesses only reach here, so a word load always has offset 0
  assign ld_sh = ld_word >> {ld_off_q, 3'b000};

  always_comb begin
    me_wb_val = byp_val_q;
    if (ld_q) begin
      case (ld_f3_q)
        3'd0:    me_wb_val = {{24{ld_sh[7]}}, ld_sh[7:0]};
        3'd1:    me_wb_val = {{16{ld_sh[15]}}, ld_sh[15:0]};
        3'd4:    me_wb_val = {24'h0, ld_sh[7:0]};
        3'd5:    me_wb_val = {16'h0, ld_sh[15:0]};
        default: me_wb_val = ld_sh;
      endcase
    end
  end

endmodule

// File: tb/tb_yarvi_lsu.sv
module tb_yarvi_lsu;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        valid, readenable, writeenable, fence;
  logic [31:0] pc, wb_val, writedata;
  logic [4:0]  wb_rd;
  logic [2:0]  funct3;
  logic        ready, sb_empty, me_valid, me_exc_misaligned, me_load_hit_store;
  logic [31:0] me_pc, me_wb_val, me_exc_mtval, code_address, code_writedata;
  logic [4:0]  me_wb_rd;
  logic [3:0]  code_writemask;

  int checks = 0;
  int errors = 0;

  yarvi_lsu dut (
    .clock(clock), .reset_n(reset_n), .valid(valid), .pc(pc), .wb_rd(wb_rd),
    .wb_val(wb_val), .readenable(readenable), .writeenable(writeenable),
    .funct3(funct3), .writedata(writedata), .fence(fence), .ready(ready),
    .sb_empty(sb_empty), .me_valid(me_valid), .me_pc(me_pc), .me_wb_rd(me_wb_rd),
    .me_wb_val(me_wb_val), .me_exc_misaligned(me_exc_misaligned),
    .me_exc_mtval(me_exc_mtval), .me_load_hit_store(me_load_hit_store),
    .code_address(code_address), .code_writedata(code_writedata),
    .code_writemask(code_writemask)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        v, rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wd;
    logic [4:0]  rdn;
    logic        e_valid;
    logic [4:0]  e_rd;
    logic [31:0] e_val;
    logic        e_mis, e_hit, e_empty;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl [NV];

  function automatic vec_t mk(logic v, logic rd, logic wr, logic [2:0] f3,
                              logic [31:0] addr, logic [31:0] wd, logic [4:0] rdn,
                              logic e_valid, logic [4:0] e_rd, logic [31:0] e_val,
                              logic e_mis, logic e_hit, logic e_empty);
    vec_t t;
    t.v = v; t.rd = rd; t.wr = wr; t.f3 = f3; t.addr = addr; t.wd = wd; t.rdn = rdn;
    t.e_valid = e_valid; t.e_rd = e_rd; t.e_val = e_val;
    t.e_mis = e_mis; t.e_hit = e_hit; t.e_empty = e_empty;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic r, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rdn,
                        input logic fn);
    valid = v; readenable = r; writeenable = w; funct3 = f3;
    wb_val = a; writedata = wd; wb_rd = rdn; fence = fn;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 3'd0, 32'h0, 32'h0, 5'd0, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    pc = 32'h0;
    idle();

    // T3 / T2 and extension / misalignment vectors
    tbl[0]  = mk(1,0,1,3'd2,32'h80000020,32'h55667788,5'd1, 1,5'd1,32'h80000020,0,0,0);
    tbl[1]  = mk(0,0,0,3'd0,32'h0,32'h0,5'd0,               0,5'd0,32'h0,0,0,1);
    tbl[2]  = mk(1,0,1,3'd2,32'h80000010,32'h11223344,5'd2, 1,5'd2,32'h80000010,0,0,0);
`ifdef LSU_FORWARD_EN
    tbl[3]  = mk(1,1,0,3'd4,32'h80000012,32'h0,5'd3,        1,5'd3,32'h00000022,0,0,0);
`else
    tbl[3]  = mk(1,1,0,3'd4,32'h80000012,32'h0,5'd3,        0,5'd0,32'h0,0,1,1);
`endif
    tbl[4]  = mk(0,0,0,3'd0,32'h0,32'h0,5'd0,               0,5'd0,32'h0,0,0,1);
    tbl[5]  = mk(1,1,0,3'd4,32'h80000012,32'h0,5'd3,        1,5'd3,32'h00000022,0,0,1);
    tbl[6]  = mk(1,1,0,3'd0,32'h80000020,32'h0,5'd4,        1,5'd4,32'hFFFFFF88,0,0,1);
    tbl[7]  = mk(1,1,0,3'd1,32'h80000022,32'h0,5'd5,        1,5'd5,32'h00005566,0,0,1);
    tbl[8]  = mk(1,1,0,3'd5,32'h80000012,32'h0,5'd6,        1,5'd6,32'h00001122,0,0,1);
    tbl[9]  = mk(1,1,0,3'd2,32'h80000010,32'h0,5'd7,        1,5'd7,32'h11223344,0,0,1);
    tbl[10] = mk(1,0,1,3'd0,32'h80000021,32'h000000AA,5'd8, 1,5'd8,32'h80000021,0,0,0);
`ifdef LSU_FORWARD_EN
    tbl[11] = mk(1,1,0,3'd2,32'h80000020,32'h0,5'd9,        1,5'd9,32'h5566AA88,0,0,0);
`else
    tbl[11] = mk(1,1,0,3'd2,32'h80000020,32'h0,5'd9,        0,5'd0,32'h0,0,1,1);
`endif
    tbl[12] = mk(0,0,0,3'd0,32'h0,32'h0,5'd0,               0,5'd0,32'h0,0,0,1);
    tbl[13] = mk(1,1,0,3'd2,32'h80000020,32'h0,5'd9,        1,5'd9,32'h5566AA88,0,0,1);
    tbl[14] = mk(1,0,1,3'd1,32'h80000030,32'h00008001,5'd10,1,5'd10,32'h80000030,0,0,0);
    tbl[15] = mk(0,0,0,3'd0,32'h0,32'h0,5'd0,               0,5'd0,32'h0,0,0,1);
    tbl[16] = mk(1,1,0,3'd1,32'h80000030,32'h0,5'd11,       1,5'd11,32'hFFFF8001,0,0,1);
    tbl[17] = mk(1,1,0,3'd0,32'h80000031,32'h0,5'd12,       1,5'd12,32'hFFFFFF80,0,0,1);
    tbl[18] = mk(1,1,0,3'd5,32'h80000030,32'h0,5'd13,       1,5'd13,32'h00008001,0,0,1);
    tbl[19] = mk(1,1,0,3'd1,32'h80000003,32'h0,5'd14,       0,5'd0,32'h80000003,1,0,1);
    tbl[20] = mk(1,0,1,3'd2,32'h80000022,32'h12345678,5'd15,0,5'd0,32'h80000022,1,0,1);
    tbl[21] = mk(1,0,0,3'd0,32'hDEADBEEF,32'h0,5'd16,       1,5'd16,32'hDEADBEEF,0,0,1);
    tbl[22] = mk(1,1,0,3'd2,32'h80000020,32'h0,5'd17,       1,5'd17,32'h5566AA88,0,0,1);
    tbl[23] = mk(1,1,0,3'd4,32'h80000023,32'h0,5'd18,       1,5'd18,32'h00000055,0,0,1);

    repeat (3) @(posedge clock);
    #1;
    chk("rst ready", 32'(ready), 32'h1);
    chk("rst sb_empty", 32'(sb_empty), 32'h1);
    chk("rst me_valid", 32'(me_valid), 32'h0);
    chk("rst me_wb_val", me_wb_val, 32'h0);
    chk("rst code_writemask", 32'(code_writemask), 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      pc = 32'h1000 + 32'(i) * 4;
      set_in(tbl[i].v, tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].rdn, 0);
      #1;
      chk($sformatf("vec%0d ready", i), 32'(ready), 32'h1);
      tick();
      chk($sformatf("vec%0d me_valid", i), 32'(me_valid), 32'(tbl[i].e_valid));
      chk($sformatf("vec%0d me_wb_rd", i), 32'(me_wb_rd), 32'(tbl[i].e_rd));
      chk($sformatf("vec%0d misaligned", i), 32'(me_exc_misaligned), 32'(tbl[i].e_mis));
      chk($sformatf("vec%0d hit_store", i), 32'(me_load_hit_store), 32'(tbl[i].e_hit));
      chk($sformatf("vec%0d sb_empty", i), 32'(sb_empty), 32'(tbl[i].e_empty));
      if (tbl[i].e_valid) begin
        chk($sformatf("vec%0d me_wb_val", i), me_wb_val, tbl[i].e_val);
        chk($sformatf("vec%0d me_pc", i), me_pc, 32'h1000 + 32'(i) * 4);
      end
      if (tbl[i].e_mis)
        chk($sformatf("vec%0d mtval", i), me_exc_mtval, tbl[i].e_val);
    end
    idle(); tick();

    // T4: back-to-back stores to one word, order must survive the drain
    set_in(1,0,1,3'd2,32'h80000070,32'h00000000,5'd1,0); #1; chk("t4 ready s1", 32'(ready), 1); tick();
    set_in(1,0,1,3'd0,32'h80000070,32'h00000011,5'd1,0); #1; chk("t4 ready s2", 32'(ready), 1); tick();
    set_in(1,0,1,3'd0,32'h80000071,32'h00000022,5'd1,0); #1; chk("t4 ready s3", 32'(ready), 1); tick();
    set_in(1,0,1,3'd1,32'h80000072,32'h00004433,5'd1,0); #1; chk("t4 ready s4", 32'(ready), 1); tick();
    set_in(1,0,1,3'd0,32'h80000070,32'h00000099,5'd1,0); #1; chk("t4 ready s5", 32'(ready), 1); tick();
    chk("t4 s5 me_valid", 32'(me_valid), 1);
    set_in(1,1,0,3'd2,32'h80000070,32'h0,5'd2,0); tick();
`ifdef LSU_FORWARD_EN
    chk("t4 fwd lw", me_wb_val, 32'h44332299);
`else
    chk("t4 replay", 32'(me_load_hit_store), 1);
`endif
    idle(); tick();
    set_in(1,1,0,3'd2,32'h80000070,32'h0,5'd2,0); tick();
    chk("t4 ram lw", me_wb_val, 32'h44332299);

    // out-of-RAM store reaches code_* only; lane-aligned drain data
    set_in(1,0,1,3'd2,32'h80000000,32'h00000000,5'd1,0); tick();
    idle(); tick();
    set_in(1,0,1,3'd2,32'h00001000,32'hFEEDFACE,5'd1,0); tick();
    idle(); tick();
    chk("oor code_address", code_address, 32'h00001000);
    chk("oor code_writedata", code_writedata, 32'hFEEDFACE);
    chk("oor code_writemask", 32'(code_writemask), 32'hF);
    set_in(1,1,0,3'd2,32'h80000000,32'h0,5'd3,0); tick();
    chk("oor ram untouched", me_wb_val, 32'h0);
    set_in(1,0,1,3'd0,32'h80000043,32'hFFFFFF5A,5'd1,0); tick();
    idle(); tick();
    chk("sb code_address", code_address, 32'h80000040);
    chk("sb code_writedata", code_writedata, 32'h5A5A5A5A);
    chk("sb code_writemask", 32'(code_writemask), 32'h8);
    set_in(1,0,1,3'd1,32'h80000042,32'hABCD1234,5'd1,0); tick();
    idle(); tick();
    chk("sh code_writedata", code_writedata, 32'h12341234);
    chk("sh code_writemask", 32'(code_writemask), 32'hC);

    // T6: three stores then fence
    set_in(1,0,1,3'd2,32'h80000050,32'hA1A1A1A1,5'd1,0); tick();
    set_in(1,0,1,3'd2,32'h80000054,32'hB2B2B2B2,5'd1,0); tick();
    chk("t6 drain1 addr", code_address, 32'h80000050);
    chk("t6 drain1 data", code_writedata, 32'hA1A1A1A1);
    chk("t6 drain1 mask", 32'(code_writemask), 32'hF);
    set_in(1,0,1,3'd2,32'h80000058,32'hC3C3C3C3,5'd1,0); tick();
    chk("t6 drain2 addr", code_address, 32'h80000054);
    chk("t6 drain2 mask", 32'(code_writemask), 32'hF);
    set_in(0,0,0,3'd0,32'h0,32'h0,5'd0,1); #1;
    chk("t6 ready at fence", 32'(ready), 1);
    tick();
    idle(); #1;
    chk("t6 drain3 addr", code_address, 32'h80000058);
    chk("t6 drain3 mask", 32'(code_writemask), 32'hF);
    chk("t6 sb_empty", 32'(sb_empty), 1);
    chk("t6 ready pending", 32'(ready), 0);
    tick();
    chk("t6 mask idle", 32'(code_writemask), 0);
    chk("t6 ready released", 32'(ready), 1);

    // fence with a non-empty SB holds off a presented load until empty
    set_in(1,0,1,3'd2,32'h80000060,32'h0BADF00D,5'd20,0); tick();
    set_in(1,1,0,3'd2,32'h80000010,32'h0,5'd21,1); #1;
    chk("f ready with fence", 32'(ready), 1);
    tick();
    chk("f load val", me_wb_val, 32'h11223344);
    chk("f sb busy", 32'(sb_empty), 0);
    set_in(1,1,0,3'd2,32'h80000010,32'h0,5'd22,0); #1;
    chk("f ready blocked", 32'(ready), 0);
    tick();
    chk("f no accept valid", 32'(me_valid), 0);
    chk("f no accept rd", 32'(me_wb_rd), 0);
    chk("f drained", 32'(sb_empty), 1);
    chk("f drain addr", code_address, 32'h80000060);
    idle(); #1;
    chk("f ready empty cycle", 32'(ready), 0);
    tick();
    chk("f ready back", 32'(ready), 1);

    // T1: reset while a store is still buffered
    set_in(1,0,1,3'd2,32'h80000040,32'h00000000,5'd1,0); tick();
    idle(); tick();
    pc = 32'h2000;
    set_in(1,0,1,3'd2,32'h80000040,32'hCAFEF00D,5'd5,0); tick();
    reset_n = 1'b0;
    idle();
    #1;
    chk("t1 me_valid", 32'(me_valid), 0);
    chk("t1 me_wb_rd", 32'(me_wb_rd), 0);
    chk("t1 me_wb_val", me_wb_val, 0);
    chk("t1 me_pc", me_pc, 0);
    chk("t1 ready", 32'(ready), 1);
    chk("t1 sb_empty", 32'(sb_empty), 1);
    chk("t1 code_address", code_address, 0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    set_in(1,1,0,3'd2,32'h80000040,32'h0,5'd6,0); tick();
    chk("t1 store discarded", me_wb_val, 32'h0);
    chk("t1 load valid", 32'(me_valid), 1);
    idle(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
